led_bank: RTL and testbench
===========================

# led_bank

Parametrised memory-mapped LED peripheral on the processor's device/command bus, successor to the fixed 8-bit LED latch. It holds an LED pattern of configurable width, supports write/set/clear/toggle commands, hardware blinking of a selectable bit mask with a programmable period, and register readback. An optional global PWM brightness stage sits between the pattern logic and the pins.

## Interface
- LED_COUNT, 8, number of LEDs; legal range 1..32
- DEVICE_ID, 5'b00000, device code this block answers to
- BLINK_DIV_W, 24, width of blink period register and counter; legal range 1..32
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- device  input  5  device select from the bus
- command  input  6  operation code
- data_in  input  32  command operand
- perf_en  input  1  qualifies the command for this cycle
- leds  output  LED_COUNT  physical LED drive, registered
- data_out  output  32  readback data, registered, zero-extended
- rd_valid  output  1  one-cycle pulse when data_out is updated

## Operation
- Command is accepted on a rising clk when device==DEVICE_ID and perf_en==1. Otherwise no state changes except the free-running counters.
- Unknown command codes are accepted and ignored; no register changes and no rd_valid.
- Operand bits: pattern and mask use data_in[LED_COUNT-1:0]; period uses data_in[BLINK_DIV_W-1:0]; upper bits are ignored.
- Commands:
  - 6'b000001 WRITE: pattern <= operand
  - 6'b000010 SET: pattern <= pattern | operand
  - 6'b000011 CLEAR: pattern <= pattern & ~operand
  - 6'b000100 TOGGLE: pattern <= pattern ^ operand
  - 6'b000101 MASK: blink_mask <= operand
  - 6'b000110 PERIOD: period <= operand; blink counter <= 0; phase <= 0
  - 6'b000111 READ: data_in[1:0] selects the source. 0 = pattern, 1 = blink_mask, 2 = period, 3 = current leds. data_out <= zero-extended value; rd_valid <= 1 for one cycle. data_out holds until the next READ.
  - 6'b001000 DUTY: PWM only; see Configuration
- Blink engine: counter of width BLINK_DIV_W.
  - If period==0: counter and phase are held at 0; blinking is disabled.
  - Otherwise the counter increments each cycle. When counter==period, the counter <= 0 and phase toggles. Each half-cycle of phase therefore lasts period+1 clocks.
- Display value: disp = pattern ^ (blink_mask & {LED_COUNT{phase}}). A masked bit alternates between its pattern value and the inverse of that value.
- leds <= disp, gated by PWM when PWM is compiled in.

## Timing
- Reset (async, immediate) sets:
  - pattern, blink_mask, period, blink counter, phase, leds, data_out: 0
  - rd_valid: 0
  - duty: 4'hF
- Command latency:
  - The register updates on the accepting edge N.
  - leds reflect the change on edge N+1, a one-cycle output pipeline.
  - data_out and rd_valid are valid after edge N. A READ of source 3 returns leds as registered before edge N.
- Back-to-back commands on consecutive cycles are all honoured in order. SET followed by READ 0 on the next cycle returns the updated pattern.
- Reset asserted mid-blink or mid-command returns every state element to its reset value; the in-flight command is discarded.
- A PERIOD write while blinking restarts the blink phase at 0 with no glitch pulse. leds follow the restarted phase one cycle later.
- Blink counter wrap: the counter never exceeds period. Lowering period below the current count cannot occur, because a PERIOD write clears the counter.

## Configuration
- LED_BANK_PWM_EN defined:
  - Adds a 4-bit duty register (DUTY command loads data_in[3:0]) and a free-running 4-bit PWM counter counting 0..14 with a period of 15 clocks.
  - leds <= disp & {LED_COUNT{pwm_cnt < duty}}. Duty 15 is always on; duty 0 is always off.
  - READ source 3 returns leds after gating.
- LED_BANK_PWM_EN undefined:
  - No duty register and no PWM counter; DUTY is treated as an unknown command and ignored.
  - leds <= disp.

## Test plan
- Reset, then WRITE 0xA5 (LED_COUNT=8, device 0, perf_en 1) -> leds==0xA5 one cycle after the accepting edge. The same command with perf_en=0 or device=1 -> leds stay 0x00.
- From pattern 0xA5, apply SET 0x0F, then CLEAR 0x81, then TOGGLE 0xFF -> pattern 0xAF, 0x2E, 0xD1. After each step, READ 0 gives data_out equal to that value with a single-cycle rd_valid pulse.
- Pattern 0x00, MASK 0x03, PERIOD 4 -> leds[1:0] alternate 00/11 every 5 clocks and leds[7:2] stay 0. PERIOD 0 -> leds[1:0] return to 00 and stay there.
- Pulse reset mid-blink, 2 clocks after a phase toggle -> leds, data_out, and rd_valid are 0 immediately. After reset, READ 2 returns 0.
- With LED_BANK_PWM_EN defined: WRITE 0xFF, DUTY 5 -> each led is high for exactly 5 of every 15 clocks. DUTY 0 -> leds constantly 0. Without the macro, DUTY 5 -> leds constantly 0xFF.
- With LED_COUNT=32 and BLINK_DIV_W=32: WRITE 0xDEADBEEF, then READ 3 two cycles later -> data_out==0xDEADBEEF. Unknown command 6'b111111 -> no state change and no rd_valid.

Source files
------------

// File: rtl/led_bank.sv
// led_bank: memory-mapped LED peripheral with write/set/clear/toggle commands,
// hardware blinking of a masked bit set, and register readback.
// Optional global PWM brightness stage enabled by defining LED_BANK_PWM_EN.
module led_bank #(
  parameter int unsigned LED_COUNT   = 8,
  parameter logic [4:0]  DEVICE_ID   = 5'b00000,
  parameter int unsigned BLINK_DIV_W = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           device,
  input  logic [5:0]           command,
  input  logic [31:0]          data_in,
  input  logic                 perf_en,
  output logic [LED_COUNT-1:0] leds,
  output logic [31:0]          data_out,
  output logic                 rd_valid
);

  localparam logic [5:0] CMD_WRITE  = 6'b000001;
  localparam logic [5:0] CMD_SET    = 6'b000010;
  localparam logic [5:0] CMD_CLEAR  = 6'b000011;
  localparam logic [5:0] CMD_TOGGLE = 6'b000100;
  localparam logic [5:0] CMD_MASK   = 6'b000101;
  localparam logic [5:0] CMD_PERIOD = 6'b000110;
  localparam logic [5:0] CMD_READ   = 6'b000111;
`ifdef LED_BANK_PWM_EN
  localparam logic [5:0] CMD_DUTY   = 6'b001000;
  localparam int unsigned PWM_W     = 4;
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(14);
`endif

  logic [LED_COUNT-1:0]   pattern_q, pattern_d;
  logic [LED_COUNT-1:0]   mask_q, mask_d;
  logic [BLINK_DIV_W-1:0] period_q, period_d;
  logic [BLINK_DIV_W-1:0] cnt_q, cnt_d;
  logic                   phase_q, phase_d;
  logic [LED_COUNT-1:0]   leds_q, leds_d;
  logic [31:0]            data_out_q, data_out_d;
  logic                   rd_valid_q, rd_valid_d;
`ifdef LED_BANK_PWM_EN
  logic [PWM_W-1:0]       duty_q, duty_d;
  logic [PWM_W-1:0]       pwm_cnt_q, pwm_cnt_d;
  logic                   pwm_on_c;
`endif

  logic                   cmd_en_c;
  logic [LED_COUNT-1:0]   op_led_c;
  logic [BLINK_DIV_W-1:0] op_per_c;
  logic [LED_COUNT-1:0]   disp_c;
  logic                   unused_c;

  // Command qualification and operand slicing; upper operand bits are don't-care
  assign cmd_en_c = perf_en && (device == DEVICE_ID);
  assign op_led_c = data_in[LED_COUNT-1:0];
  assign op_per_c = data_in[BLINK_DIV_W-1:0];
  assign unused_c = ^data_in;

  // Masked bits are inverted while the blink phase is high
  assign disp_c = pattern_q ^ (mask_q & {LED_COUNT{phase_q}});

`ifdef LED_BANK_PWM_EN
  // Free-running 0..14 PWM counter; LEDs lit while counter is below duty
  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_W'(1);
    pwm_on_c  = (pwm_cnt_q < duty_q);
    leds_d    = disp_c & {LED_COUNT{pwm_on_c}};
  end
`else
  // Without PWM the display value drives the pins directly
  always_comb begin
    leds_d = disp_c;
  end
`endif

  // Blink engine, command decode and readback next-state
  always_comb begin
    pattern_d  = pattern_q;
    mask_d     = mask_q;
    period_d   = period_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
`ifdef LED_BANK_PWM_EN
    duty_d     = duty_q;
`endif

    if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == period_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + BLINK_DIV_W'(1);
      phase_d = phase_q;
    end

    if (cmd_en_c) begin
      case (command)
        CMD_WRITE:  pattern_d = op_led_c;
        CMD_SET:    pattern_d = pattern_q | op_led_c;
        CMD_CLEAR:  pattern_d = pattern_q & ~op_led_c;
        CMD_TOGGLE: pattern_d = pattern_q ^ op_led_c;
        CMD_MASK:   mask_d    = op_led_c;
        CMD_PERIOD: begin
          period_d = op_per_c;
          cnt_d    = '0;
          phase_d  = 1'b0;
        end
        CMD_READ: begin
          rd_valid_d = 1'b1;
          case (data_in[1:0])
            2'd0:    data_out_d = 32'(pattern_q);
            2'd1:    data_out_d = 32'(mask_q);
            2'd2:    data_out_d = 32'(period_q);
            default: data_out_d = 32'(leds_q);
          endcase
        end
`ifdef LED_BANK_PWM_EN
        CMD_DUTY:   duty_d = data_in[PWM_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q  <= '0;
      mask_q     <= '0;
      period_q   <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      leds_q     <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
`ifdef LED_BANK_PWM_EN
      duty_q     <= 4'hF;
      pwm_cnt_q  <= '0;
`endif
    end else begin
      pattern_q  <= pattern_d;
      mask_q     <= mask_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      leds_q     <= leds_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
`ifdef LED_BANK_PWM_EN
      duty_q     <= duty_d;
      pwm_cnt_q  <= pwm_cnt_d;
`endif
    end
  end

  assign leds     = leds_q;
  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_led_bank.sv
// Directed bench for led_bank: a default 8-LED instance on device 0 and a
// 32-LED / 32-bit-period instance on device 3 sharing one command bus.
module tb_led_bank;

  localparam logic [5:0] WRITE  = 6'b000001;
  localparam logic [5:0] SET    = 6'b000010;
  localparam logic [5:0] CLEAR  = 6'b000011;
  localparam logic [5:0] TOGGLE = 6'b000100;
  localparam logic [5:0] MASK   = 6'b000101;
  localparam logic [5:0] PERIOD = 6'b000110;
  localparam logic [5:0] READ   = 6'b000111;
  localparam logic [5:0] DUTY   = 6'b001000;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  device;
  logic [5:0]  command;
  logic [31:0] data_in;
  logic        perf_en;
  logic [7:0]  leds_n;
  logic [31:0] dout_n;
  logic        rv_n;
  logic [31:0] leds_w;
  logic [31:0] dout_w;
  logic        rv_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_bank #(.LED_COUNT(8), .DEVICE_ID(5'd0), .BLINK_DIV_W(24)) u_dut (
    .clk(clk), .reset(reset), .device(device), .command(command),
    .data_in(data_in), .perf_en(perf_en),
    .leds(leds_n), .data_out(dout_n), .rd_valid(rv_n)
  );

  led_bank #(.LED_COUNT(32), .DEVICE_ID(5'd3), .BLINK_DIV_W(32)) u_wide (
    .clk(clk), .reset(reset), .device(device), .command(command),
    .data_in(data_in), .perf_en(perf_en),
    .leds(leds_w), .data_out(dout_w), .rd_valid(rv_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one command for exactly one rising edge; return 1ns after that edge
  task automatic issue(input logic [4:0] dev, input logic [5:0] op,
                       input logic [31:0] d, input logic en);
    @(negedge clk);
    device = dev; command = op; data_in = d; perf_en = en;
    @(posedge clk);
    #1;
    perf_en = 1'b0; command = '0; data_in = '0; device = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected blink leds[1:0] k edges after a PERIOD 4 write from phase 0
  function automatic logic [31:0] blink_exp(input int k);
    return (((k - 1) / 5) % 2 == 1) ? 32'h03 : 32'h00;
  endfunction

  initial begin
    int high;
    reset = 1'b1; device = '0; command = '0; data_in = '0; perf_en = 1'b0;
    #2;
    check("reset_leds", 32'(leds_n), 32'h0);
    check("reset_dout", dout_n, 32'h0);
    check("reset_rv", 32'(rv_n), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Qualification: perf_en low, then wrong device
    issue(5'd0, WRITE, 32'hA5, 1'b0); tick();
    check("no_perf_en", 32'(leds_n), 32'h00);
    issue(5'd1, WRITE, 32'hA5, 1'b1); tick();
    check("wrong_device", 32'(leds_n), 32'h00);

    // WRITE with one-cycle output pipeline
    issue(5'd0, WRITE, 32'hA5, 1'b1);
    check("write_lag", 32'(leds_n), 32'h00);
    tick();
    check("write", 32'(leds_n), 32'hA5);

    // SET / CLEAR / TOGGLE each followed directly by READ 0
    issue(5'd0, SET, 32'h0F, 1'b1);
    issue(5'd0, READ, 32'd0, 1'b1);
    check("set_read", dout_n, 32'hAF);
    check("set_rv", 32'(rv_n), 32'h1);
    tick();
    check("rv_pulse_end", 32'(rv_n), 32'h0);
    check("dout_hold", dout_n, 32'hAF);
    issue(5'd0, CLEAR, 32'h81, 1'b1);
    issue(5'd0, READ, 32'd0, 1'b1);
    check("clear_read", dout_n, 32'h2E);
    check("clear_rv", 32'(rv_n), 32'h1);
    issue(5'd0, TOGGLE, 32'hFF, 1'b1);
    issue(5'd0, READ, 32'd0, 1'b1);
    check("toggle_read", dout_n, 32'hD1);
    check("toggle_rv", 32'(rv_n), 32'h1);

    // READ 3 returns leds as registered before the accepting edge
    tick();
    issue(5'd0, WRITE, 32'h3C, 1'b1);
    issue(5'd0, READ, 32'd3, 1'b1);
    check("read3_old", dout_n, 32'hD1);
    issue(5'd0, READ, 32'd3, 1'b1);
    check("read3_new", dout_n, 32'h3C);

    // Unknown opcode: no rd_valid, no state change
    issue(5'd0, 6'h3F, 32'hFF, 1'b1);
    check("unknown_rv", 32'(rv_n), 32'h0);
    issue(5'd0, READ, 32'd0, 1'b1);
    check("unknown_pattern", dout_n, 32'h3C);
    issue(5'd0, READ, 32'd2, 1'b1);
    check("period_reset", dout_n, 32'h0);

    // Blink: pattern 0, mask 3 (upper operand bits ignored), period 4
    issue(5'd0, WRITE, 32'h00, 1'b1);
    issue(5'd0, MASK, 32'hABCDEF03, 1'b1);
    issue(5'd0, READ, 32'd1, 1'b1);
    check("mask_read", dout_n, 32'h03);
    issue(5'd0, PERIOD, 32'hFF000004, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      tick();
      check($sformatf("blink_k%0d", k), 32'(leds_n), blink_exp(k));
    end
    issue(5'd0, PERIOD, 32'd0, 1'b1);
    check("period0_lag", 32'(leds_n), 32'h03);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("period0_k%0d", k), 32'(leds_n), 32'h00);
    end

    // Restart blink, then reset two clocks after the first toggle
    issue(5'd0, PERIOD, 32'd4, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("reblink_k%0d", k), 32'(leds_n), blink_exp(k));
    end
    issue(5'd0, READ, 32'd1, 1'b1);
    check("pre_reset_leds", 32'(leds_n), 32'h03);
    check("pre_reset_rv", 32'(rv_n), 32'h1);
    check("pre_reset_dout", dout_n, 32'h03);
    #1 reset = 1'b1;
    #1;
    check("midreset_leds", 32'(leds_n), 32'h0);
    check("midreset_dout", dout_n, 32'h0);
    check("midreset_rv", 32'(rv_n), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    issue(5'd0, READ, 32'd2, 1'b1);
    check("post_reset_period", dout_n, 32'h0);
    issue(5'd0, READ, 32'd1, 1'b1);
    check("post_reset_mask", dout_n, 32'h0);
    tick(); tick();
    check("post_reset_leds", 32'(leds_n), 32'h0);

    // Wide instance on device 3
    issue(5'd3, WRITE, 32'hDEADBEEF, 1'b1);
    tick();
    issue(5'd3, READ, 32'd3, 1'b1);
    check("wide_read3", dout_w, 32'hDEADBEEF);
    check("wide_rv", 32'(rv_w), 32'h1);
    check("narrow_not_selected_rv", 32'(rv_n), 32'h0);
    check("narrow_not_selected_leds", 32'(leds_n), 32'h0);
    issue(5'd3, 6'h3F, 32'h12345678, 1'b1);
    check("wide_unknown_rv", 32'(rv_w), 32'h0);
    check("wide_unknown_leds", leds_w, 32'hDEADBEEF);
    issue(5'd3, READ, 32'd0, 1'b1);
    check("wide_pattern", dout_w, 32'hDEADBEEF);
    issue(5'd3, PERIOD, 32'hFFFFFFFF, 1'b1);
    issue(5'd3, READ, 32'd2, 1'b1);
    check("wide_period", dout_w, 32'hFFFFFFFF);

    // Brightness: duty 5, then duty 0
    issue(5'd0, WRITE, 32'hFF, 1'b1);
    issue(5'd0, DUTY, 32'd5, 1'b1);
    check("duty_rv", 32'(rv_n), 32'h0);
    high = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      check($sformatf("duty5_level_k%0d", k),
            32'((leds_n == 8'h00) || (leds_n == 8'hFF)), 32'h1);
      if (leds_n == 8'hFF) high++;
    end
`ifdef LED_BANK_PWM_EN
    check("duty5_high", 32'(high), 32'd5);
`else
    check("duty5_high", 32'(high), 32'd15);
`endif
    issue(5'd0, DUTY, 32'd0, 1'b1);
    tick();
    for (int k = 0; k < 15; k++) begin
      tick();
`ifdef LED_BANK_PWM_EN
      check($sformatf("duty0_k%0d", k), 32'(leds_n), 32'h00);
`else
      check($sformatf("duty0_k%0d", k), 32'(leds_n), 32'hFF);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
